// File: rtl/mfm_pkg.sv
// mfm_pkg: shared types and constants for the MFM read path.
// Sync mark, CRC-16-CCITT constants and a byte-serial CRC step.
package mfm_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PLLRST,
      S_HUNT,
      S_SYNC,
      S_DATA,
      S_DONE
   } state_t;

   localparam logic [15:0] SYNC_A1    = 16'h4489;
   localparam logic [15:0] CRC_PRESET = 16'hCDB4;
   localparam logic [15:0] CRC_POLY   = 16'h1021;

   function automatic logic [15:0] crc16_byte(
      input logic [15:0] crc,
      input logic [7:0]  d
   );
      logic [15:0] c;
      c = crc ^ {d, 8'h00};
      for (int i = 0; i < 8; i++)
         c = c[15] ? ({c[14:0], 1'b0} ^ CRC_POLY)
                   : {c[14:0], 1'b0};
      return c;
   endfunction

endpackage

// File: rtl/mfm_crc16.sv
// mfm_crc16: byte-serial CRC-16-CCITT accumulator for the data field.
// init reloads the post-sync preset; en folds one byte in.
module mfm_crc16
   import mfm_pkg::*;
(
   input  logic        clk_50,
   input  logic        reset,
   input  logic        init,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [15:0] crc
);

   always_ff @(posedge clk_50 or negedge reset) begin
      if (!reset)
         crc <= CRC_PRESET;
      else if (init)
         crc <= CRC_PRESET;
      else if (en)
         crc <= crc16_byte(crc, data);
   end

endmodule

// File: rtl/mfm_read_ctrl.sv
// mfm_read_ctrl: MFM sector read sequencer (PLL restart, sync hunt, deframe).
// Define MFM_READ_CRC_EN to deliver and check the CRC-16 trailer.
module mfm_read_ctrl
   import mfm_pkg::*;
#(
   parameter int SECTOR_BYTES = 512,
   parameter int HUNT_CELLS   = 16384,
   parameter int RETRIES      = 3,
   parameter int DPLL_RST_CYC = 4
) (
   input  logic       clk_50,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic       clk_5,
   input  logic       raw_mfm,
   output logic       dpll_reset,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   input  logic       byte_ready,
   output logic       busy,
   output logic       done,
   output logic       err_timeout,
   output logic       err_overrun,
   output logic       crc_err
);

`ifdef MFM_READ_CRC_EN
   localparam int FRAME = SECTOR_BYTES + 2;
`else
   localparam int FRAME = SECTOR_BYTES;
`endif
   localparam int BW = $clog2(SECTOR_BYTES + 3);
   localparam int HW = $clog2(HUNT_CELLS + 1);
   localparam int RW = $clog2(RETRIES + 2);
   localparam int CW = $clog2(DPLL_RST_CYC + 1);

   localparam logic [BW-1:0] FRAME_LAST = BW'(FRAME - 1);
   localparam logic [HW-1:0] HUNT_LAST  = HW'(HUNT_CELLS - 1);
   localparam logic [RW-1:0] RETRY_MAX  = RW'(RETRIES);
   localparam logic [CW-1:0] RST_LAST   = CW'(DPLL_RST_CYC - 1);

   state_t state, nstate;

   logic          clk5_q, clk5_qq;
   logic          boundary;
   logic          flag;
   logic          cell_bit;
   logic [14:0]   sh;
   logic [15:0]   sh_next;
   logic [3:0]    phase;
   logic [1:0]    marks;
   logic [6:0]    dbyte;
   logic [HW-1:0] hunt_cnt;
   logic [RW-1:0] retry_cnt;
   logic [CW-1:0] rst_cnt;
   logic [BW-1:0] byte_cnt;

   logic done_d;
   logic to_set;
   logic retry;
   logic sync_hit;
   logic byte_end;
   logic abort_hit;

   // clk_5 is only sampled; each edge of it ends one cell
   assign boundary  = clk5_q ^ clk5_qq;
   assign cell_bit  = flag | raw_mfm;
   assign sh_next   = {sh, cell_bit};
   assign abort_hit = abort && (state != S_IDLE);
   assign sync_hit  = boundary && (state == S_SYNC) &&
                      (phase == 4'd15) && (sh_next == SYNC_A1);
   assign byte_end  = boundary && (state == S_DATA) &&
                      (phase == 4'd15);

   assign busy       = (state != S_IDLE) && (state != S_DONE);
   assign dpll_reset = (state != S_PLLRST);

   always_comb begin
      nstate = state;
      done_d = 1'b0;
      to_set = 1'b0;
      retry  = 1'b0;
      unique case (state)
         S_IDLE:
            if (start) nstate = S_PLLRST;
         S_PLLRST:
            if (rst_cnt == RST_LAST) nstate = S_HUNT;
         S_HUNT:
            if (boundary) begin
               if (sh_next == SYNC_A1) begin
                  nstate = S_SYNC;
               end else if (hunt_cnt == HUNT_LAST) begin
                  if (retry_cnt < RETRY_MAX) begin
                     nstate = S_PLLRST;
                     retry  = 1'b1;
                  end else begin
                     nstate = S_DONE;
                     to_set = 1'b1;
                  end
               end
            end
         S_SYNC:
            if (boundary && (phase == 4'd15)) begin
               if (sh_next != SYNC_A1)
                  nstate = S_HUNT;
               else if (marks == 2'd2)
                  nstate = S_DATA;
            end
         S_DATA:
            if (byte_end && (byte_cnt == FRAME_LAST))
               nstate = S_DONE;
         S_DONE:
            if (!byte_valid) begin
               nstate = S_IDLE;
               done_d = 1'b1;
            end
         default:
            nstate = S_IDLE;
      endcase
      if (abort_hit) begin
         nstate = S_IDLE;
         done_d = 1'b0;
         to_set = 1'b0;
         retry  = 1'b0;
      end
   end

   always_ff @(posedge clk_50 or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         clk5_q      <= 1'b0;
         clk5_qq     <= 1'b0;
         flag        <= 1'b0;
         sh          <= '0;
         phase       <= '0;
         marks       <= '0;
         dbyte       <= '0;
         hunt_cnt    <= '0;
         retry_cnt   <= '0;
         rst_cnt     <= '0;
         byte_cnt    <= '0;
         byte_data   <= '0;
         byte_valid  <= 1'b0;
         done        <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         state   <= nstate;
         clk5_q  <= clk_5;
         clk5_qq <= clk5_q;
         done    <= done_d;

         if (boundary) begin
            flag  <= 1'b0;
            sh    <= sh_next[14:0];
            phase <= phase + 4'd1;
            if (phase[0])
               dbyte <= {dbyte[5:0], cell_bit};
         end else if (raw_mfm) begin
            flag <= 1'b1;
         end

         if (state == S_IDLE) begin
            retry_cnt <= '0;
            rst_cnt   <= '0;
            if (start) begin
               err_timeout <= 1'b0;
               err_overrun <= 1'b0;
            end
         end

         if (state == S_PLLRST) begin
            rst_cnt  <= rst_cnt + CW'(1);
            flag     <= 1'b0;
            sh       <= '0;
            phase    <= '0;
            hunt_cnt <= '0;
            byte_cnt <= '0;
         end

         if ((state == S_HUNT) && boundary) begin
            hunt_cnt <= hunt_cnt + HW'(1);
            if (sh_next == SYNC_A1) begin
               marks <= 2'd1;
               phase <= '0;
            end
         end

         if (retry) begin
            retry_cnt <= retry_cnt + RW'(1);
            rst_cnt   <= '0;
         end
         if (to_set)
            err_timeout <= 1'b1;
         if (sync_hit)
            marks <= marks + 2'd1;

         // a byte finishing while the held one is unread is dropped
         if (byte_end) begin
            byte_cnt <= byte_cnt + BW'(1);
            if (byte_valid && !byte_ready) begin
               err_overrun <= 1'b1;
            end else begin
               byte_data  <= {dbyte, cell_bit};
               byte_valid <= 1'b1;
            end
         end else if (byte_valid && byte_ready) begin
            byte_valid <= 1'b0;
         end

         if (abort_hit)
            byte_valid <= 1'b0;
      end
   end

`ifdef MFM_READ_CRC_EN
   logic [15:0] crc;
   logic        crc_init;

   assign crc_init = (state == S_SYNC) && (nstate == S_DATA);

   mfm_crc16 u_crc (
      .clk_50 (clk_50),
      .reset  (reset),
      .init   (crc_init),
      .en     (byte_end),
      .data   ({dbyte, cell_bit}),
      .crc    (crc)
   );

   // trailer included, so a clean sector leaves a zero residue
   always_ff @(posedge clk_50 or negedge reset) begin
      if (!reset)
         crc_err <= 1'b0;
      else if ((state == S_IDLE) && start)
         crc_err <= 1'b0;
      else if (done_d)
         crc_err <= !err_timeout && (crc != 16'h0000);
   end
`else
   assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_mfm_read_ctrl.sv
// tb_mfm_read_ctrl: directed + randomized sector reads against a
// byte-level model (MFM encoder, CRC over A1 A1 A1 + data).
module tb_mfm_read_ctrl;

   localparam int NB = 4;
`ifdef MFM_READ_CRC_EN
   localparam int FRAME = NB + 2;
`else
   localparam int FRAME = NB;
`endif

   logic       clk_50 = 1'b0;
   logic       reset;
   logic       start;
   logic       abort;
   logic       clk_5;
   logic       raw_mfm;
   logic       byte_ready;
   logic       dpll_reset;
   logic [7:0] byte_data;
   logic       byte_valid;
   logic       busy;
   logic       done;
   logic       err_timeout;
   logic       err_overrun;
   logic       crc_err;

   int compared   = 0;
   int mismatched = 0;

   bit         cells[$];
   logic [7:0] frame[$];
   logic [7:0] exp_q[$];
   logic [7:0] got[$];
   logic [7:0] dat[NB];
   logic       prev_d;
   int         win[$];
   int         cur_win    = 0;
   int         done_cnt   = 0;
   int         valid_seen = 0;

   always #10 clk_50 = ~clk_50;

   mfm_read_ctrl #(
      .SECTOR_BYTES (NB),
      .HUNT_CELLS   (64),
      .RETRIES      (1),
      .DPLL_RST_CYC (4)
   ) dut (
      .clk_50      (clk_50),
      .reset       (reset),
      .start       (start),
      .abort       (abort),
      .clk_5       (clk_5),
      .raw_mfm     (raw_mfm),
      .dpll_reset  (dpll_reset),
      .byte_data   (byte_data),
      .byte_valid  (byte_valid),
      .byte_ready  (byte_ready),
      .busy        (busy),
      .done        (done),
      .err_timeout (err_timeout),
      .err_overrun (err_overrun),
      .crc_err     (crc_err)
   );

   // inputs only change at posedge+2, so negedge sees what the next edge uses
   always @(negedge clk_50) begin
      if (byte_valid && byte_ready) got.push_back(byte_data);
      if (byte_valid) valid_seen++;
      if (done) done_cnt++;
      if (!dpll_reset) cur_win++;
      else if (cur_win != 0) begin
         win.push_back(cur_win);
         cur_win = 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_50);
         #2;
      end
   endtask

   function automatic logic [15:0] crc_bits(input logic [15:0] c,
                                            input logic [7:0] b);
      logic fb;
      for (int i = 7; i >= 0; i--) begin
         fb = c[15] ^ b[i];
         c  = {c[14:0], 1'b0};
         if (fb) c = c ^ 16'h1021;
      end
      return c;
   endfunction

   task automatic add_word(input logic [15:0] w);
      for (int i = 15; i >= 0; i--) cells.push_back(w[i]);
      prev_d = 1'b1;
   endtask

   task automatic add_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         cells.push_back(!prev_d && !b[i]);
         cells.push_back(b[i]);
         prev_d = b[i];
      end
   endtask

   task automatic build_sector(input int pre, input bit sync_fail,
                               input bit flip);
`ifdef MFM_READ_CRC_EN
      logic [15:0] c;
`endif
      frame.delete();
      cells.delete();
      for (int i = 0; i < NB; i++) frame.push_back(dat[i]);
`ifdef MFM_READ_CRC_EN
      c = 16'hFFFF;
      for (int i = 0; i < 3; i++) c = crc_bits(c, 8'hA1);
      foreach (frame[i]) c = crc_bits(c, frame[i]);
      frame.push_back(c[15:8]);
      frame.push_back(c[7:0]);
`endif
      if (flip) frame[0] = frame[0] ^ 8'h08;
      prev_d = 1'b0;
      repeat (pre) add_byte(8'h00);
      if (sync_fail) begin
         add_word(16'h4489);
         add_word(16'h4489);
         add_byte(8'h00);
      end
      repeat (3) add_word(16'h4489);
      foreach (frame[i]) add_byte(frame[i]);
   endtask

   // one cell = 5 clk_50 cycles, pulse mid-cell, clk_5 edge closes it
   task automatic send_cells(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         tick(2);
         raw_mfm = cells[i];
         tick(1);
         raw_mfm = 1'b0;
         tick(2);
         clk_5 = ~clk_5;
      end
   endtask

   task automatic start_read();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      chk("busy_rise", busy, 1'b1);
      chk("dpll_low", dpll_reset, 1'b0);
      chk("err_clr_ovr", err_overrun, 1'b0);
      chk("err_clr_to", err_timeout, 1'b0);
      tick(6);
   endtask

   task automatic check_bytes(input string tag, input int base);
      logic [7:0] g;
      chk({tag, "_cnt"}, got.size() - base, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         g = (base + i < got.size()) ? got[base + i] : 8'hxx;
         chk(tag, g, exp_q[i]);
      end
   endtask

   task automatic clean_read(input string tag, input int pre,
                             input bit sync_fail, input bit flip);
      int gb, db;
      byte_ready = 1'b1;
      build_sector(pre, sync_fail, flip);
      gb = got.size();
      db = done_cnt;
      start_read();
      send_cells(0, cells.size());
      tick(20);
      exp_q = frame;
      check_bytes(tag, gb);
      chk({tag, "_done"}, done_cnt - db, 1);
      chk({tag, "_ovr"}, err_overrun, 1'b0);
      chk({tag, "_to"}, err_timeout, 1'b0);
      chk({tag, "_crc"}, crc_err, flip);
      chk({tag, "_busy"}, busy, 1'b0);
   endtask

   initial begin
      int n1, gb, db, wb, vb;
      reset      = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      clk_5      = 1'b0;
      raw_mfm    = 1'b0;
      byte_ready = 1'b0;
      tick(3);
      chk("rst_dpll", dpll_reset, 1'b1);
      chk("rst_data", byte_data, 8'h00);
      chk("rst_valid", byte_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_to", err_timeout, 1'b0);
      chk("rst_ovr", err_overrun, 1'b0);
      chk("rst_crc", crc_err, 1'b0);
      reset = 1'b1;
      tick(3);

      dat = '{8'h12, 8'h34, 8'h56, 8'h78};
      clean_read("clean", 2, 1'b0, 1'b0);

      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < NB; i++) dat[i] = 8'($urandom);
         clean_read("rand", 1 + k, 1'b0, 1'b0);
      end

      for (int i = 0; i < NB; i++) dat[i] = 8'($urandom);
      clean_read("syncfail", 1, 1'b1, 1'b0);

      // no sync at all: two PLL restarts then timeout
      byte_ready = 1'b1;
      cells.delete();
      prev_d = 1'b0;
      repeat (12) add_byte(8'h00);
      wb = win.size();
      db = done_cnt;
      vb = valid_seen;
      start_read();
      send_cells(0, cells.size());
      tick(10);
      chk("to_windows", win.size() - wb, 2);
      chk("to_win0", (win.size() > wb) ? win[wb] : -1, 4);
      chk("to_win1", (win.size() > wb + 1) ? win[wb + 1] : -1, 4);
      chk("to_flag", err_timeout, 1'b1);
      chk("to_done", done_cnt - db, 1);
      chk("to_novalid", valid_seen - vb, 0);
      chk("to_busy", busy, 1'b0);

      // consumer stalls across the second byte
      byte_ready = 1'b0;
      for (int i = 0; i < NB; i++) dat[i] = 8'($urandom);
      build_sector(1, 1'b0, 1'b0);
      n1 = 16 + 48 + 32;
      gb = got.size();
      db = done_cnt;
      start_read();
      send_cells(0, n1);
      tick(3);
      chk("ovr_valid", byte_valid, 1'b1);
      chk("ovr_held", byte_data, frame[0]);
      chk("ovr_flag", err_overrun, 1'b1);
      byte_ready = 1'b1;
      send_cells(n1, cells.size());
      tick(20);
      exp_q = frame;
      exp_q.delete(1);
      check_bytes("ovr_bytes", gb);
      chk("ovr_done", done_cnt - db, 1);
      chk("ovr_sticky", err_overrun, 1'b1);

      // abort with a byte pending
      byte_ready = 1'b0;
      for (int i = 0; i < NB; i++) dat[i] = 8'($urandom);
      build_sector(1, 1'b0, 1'b0);
      db = done_cnt;
      start_read();
      send_cells(0, n1);
      tick(3);
      chk("ab_pre_valid", byte_valid, 1'b1);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      chk("ab_busy", busy, 1'b0);
      chk("ab_valid", byte_valid, 1'b0);
      chk("ab_dpll", dpll_reset, 1'b1);
      chk("ab_ovr_kept", err_overrun, 1'b1);
      tick(10);
      chk("ab_nodone", done_cnt - db, 0);
      for (int i = 0; i < NB; i++) dat[i] = 8'($urandom);
      clean_read("after_ab", 1, 1'b0, 1'b0);

`ifdef MFM_READ_CRC_EN
      dat = '{8'h12, 8'h34, 8'h56, 8'h78};
      clean_read("crc_bad", 1, 1'b0, 1'b1);
      clean_read("crc_good", 1, 1'b0, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
